// File: rtl/boolexp_pkg.sv
// Shared types and constants for the boolean-expression sweep checker.
package boolexp_pkg;

    localparam int unsigned N_IN   = 3;
    localparam int unsigned N_COMB = 8;
    localparam int unsigned IDX_W  = $clog2(N_COMB);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [IDX_W-1:0] fail_idx;
        logic             fail_valid;
    } err_log_t;

    // Lowest bit position where the two tables disagree; 0 when they match.
    function automatic logic [IDX_W-1:0] first_diff(input logic [N_COMB-1:0] got,
                                                    input logic [N_COMB-1:0] exp);
        logic [IDX_W-1:0] pos;
        pos = '0;
        for (int i = N_COMB - 1; i >= 0; i--) begin
            if (got[i] != exp[i]) begin
                pos = IDX_W'(i);
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/boolexp_sweep_checker_timer.sv
// Hold counter: last is high on the final held cycle of a combination.
module sweep_timer #(
    parameter int unsigned HOLD_CYCLES = 100,
    parameter int unsigned CNT_W       = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A clear with en set counts the clearing edge as the first held cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = en ? CNT_W'(1) : '0;
        end else if (en) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == CNT_LAST);

endmodule

// File: rtl/boolexp_sweep_checker.sv
// Drives a,b,c through all eight combinations, captures y into a truth table
// and compares it with EXPECTED. Define ERR_LOG_EN to add fail_idx/fail_valid.
module boolexp_sweep_checker
    import boolexp_pkg::*;
#(
    parameter int unsigned        HOLD_CYCLES = 100,
    parameter logic [N_COMB-1:0]  EXPECTED    = 8'b1110_1000,
    parameter int unsigned        CNT_W       = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              a,
    output logic              b,
    output logic              c,
    input  logic              y,
    output logic              busy,
    output logic              done,
    output logic              pass,
`ifdef ERR_LOG_EN
    output logic [IDX_W-1:0]  fail_idx,
    output logic              fail_valid,
`endif
    output logic [N_COMB-1:0] table_o
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_COMB - 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [N_IN-1:0]     abc_q, abc_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [N_COMB-1:0]   table_q, table_d;
    logic [N_COMB-1:0]   cap_table;
    logic                timer_clr;
    logic                timer_en;
    logic                timer_last;
`ifdef ERR_LOG_EN
    err_log_t            err_q, err_d;
`endif

    sweep_timer #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (timer_clr),
        .en   (timer_en),
        .last (timer_last)
    );

    // Next state, capture and verdict; cap_table folds in the bit sampled this edge.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        abc_d     = abc_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        table_d   = table_q;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
`ifdef ERR_LOG_EN
        err_d     = err_q;
`endif
        cap_table        = table_q;
        cap_table[idx_q] = y;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    idx_d     = '0;
                    abc_d     = '0;
                    table_d   = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    timer_clr = 1'b1;
                    timer_en  = 1'b1;
`ifdef ERR_LOG_EN
                    err_d     = '0;
`endif
                end
            end
            ST_RUN: begin
                timer_en = 1'b1;
                if (timer_last) begin
                    table_d = cap_table;
                    if (idx_q != IDX_LAST) begin
                        idx_d = idx_q + IDX_W'(1);
                        abc_d = N_IN'(idx_q + IDX_W'(1));
                    end else begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (cap_table == EXPECTED);
`ifdef ERR_LOG_EN
                        err_d.fail_valid = (cap_table != EXPECTED);
                        err_d.fail_idx   = first_diff(cap_table, EXPECTED);
`endif
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            abc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            table_q <= '0;
`ifdef ERR_LOG_EN
            err_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            abc_q   <= abc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            table_q <= table_d;
`ifdef ERR_LOG_EN
            err_q   <= err_d;
`endif
        end
    end

    assign {a, b, c} = abc_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign table_o   = table_q;
`ifdef ERR_LOG_EN
    assign fail_idx   = err_q.fail_idx;
    assign fail_valid = err_q.fail_valid;
`endif

endmodule

// File: tb/tb_boolexp_sweep_checker.sv
// Self-checking bench for boolexp_sweep_checker with HOLD_CYCLES=4.
module tb_boolexp_sweep_checker;

    localparam int unsigned H     = 4;
    localparam logic [7:0]  GOLD  = 8'hE8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       y;
    logic       a, b, c;
    logic       busy, done, pass;
    logic [7:0] table_o;
`ifdef ERR_LOG_EN
    logic [2:0] fail_idx;
    logic       fail_valid;
`endif

    int n_vec = 0;
    int n_bad = 0;

    // Response model: 0 majority, 1 parity, 2 high for first two cycles of a window, 3 lookup table
    int         mode = 0;
    logic [7:0] rtbl = 8'h00;
    int         age = 0;
    logic [2:0] abc_prev = 3'b000;
    logic       busy_prev = 1'b0;

    boolexp_sweep_checker #(
        .HOLD_CYCLES (H),
        .EXPECTED    (GOLD),
        .CNT_W       (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .c          (c),
        .y          (y),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
`ifdef ERR_LOG_EN
        .fail_idx   (fail_idx),
        .fail_valid (fail_valid),
`endif
        .table_o    (table_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [2:0] abc;
        abc = {a, b, c};
        if (abc != abc_prev || (busy && !busy_prev)) age = 0;
        else age = age + 1;
        abc_prev  = abc;
        busy_prev = busy;
        case (mode)
            0: y = (a & b) | (a & c) | (b & c);
            1: y = a ^ b ^ c;
            2: y = (age < 2);
            default: y = rtbl[abc];
        endcase
    end

    typedef struct {
        int         mode;
        logic [7:0] tbl;
        logic [7:0] exp_tbl;
        logic       exp_pass;
        logic [2:0] exp_fidx;
        int         p1;
        int         p2;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] ref_fidx(input logic [7:0] got);
        logic [7:0] g;
        g = GOLD;
        for (int i = 0; i < 8; i++) begin
            if (got[i] != g[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    // One full sweep from IDLE or DONE; start re-pulsed at edges k+p1 and k+p2 while busy.
    task automatic run_sweep(input vec_t v);
        int exp_abc;
        mode  = v.mode;
        rtbl  = v.tbl;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_done", 32'(done), 32'd0);
        chk("start_pass", 32'(pass), 32'd0);
        chk("start_table", 32'(table_o), 32'd0);
        for (int j = 1; j <= 31; j++) begin
            start = (j == v.p1 || j == v.p2);
            step();
            start = 1'b0;
            exp_abc = (j + 1) / H;
            if (exp_abc > 7) exp_abc = 7;
            chk("abc", 32'({a, b, c}), 32'(exp_abc));
            chk("done_edge", 32'(done), 32'(j == 31));
        end
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_table", 32'(table_o), 32'(v.exp_tbl));
        chk("end_pass", 32'(pass), 32'(v.exp_pass));
`ifdef ERR_LOG_EN
        chk("fail_valid", 32'(fail_valid), 32'(!v.exp_pass));
        chk("fail_idx", 32'(fail_idx), 32'(v.exp_fidx));
`endif
        step();
        chk("done_hold", 32'(done), 32'd1);
        chk("table_hold", 32'(table_o), 32'(v.exp_tbl));
    endtask

    initial begin
        vec_t rv;
        vecs[0] = '{0, 8'h00, 8'hE8, 1'b1, 3'd0, -1, -1};
        vecs[1] = '{1, 8'h00, 8'h96, 1'b0, 3'd1, -1, -1};
        vecs[2] = '{2, 8'h00, 8'h00, 1'b0, 3'd3, -1, -1};
        vecs[3] = '{0, 8'h00, 8'hE8, 1'b1, 3'd0,  5, 20};

        rst   = 1'b1;
        start = 1'b0;
        y     = 1'b0;
        step();
        step();
        chk("rst_abc", 32'({a, b, c}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_table", 32'(table_o), 32'd0);
`ifdef ERR_LOG_EN
        chk("rst_fvalid", 32'(fail_valid), 32'd0);
        chk("rst_fidx", 32'(fail_idx), 32'd0);
`endif
        rst = 1'b0;
        step();

        for (int i = 0; i < 4; i++) run_sweep(vecs[i]);

        // Reset mid-sweep at edge k+13, then a fresh sweep.
        mode  = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int j = 1; j <= 12; j++) step();
        chk("mid_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_table", 32'(table_o), 32'd0);
        chk("mid_abc", 32'({a, b, c}), 32'd0);
        step();
        chk("mid_idle", 32'(busy), 32'd0);
        run_sweep(vecs[0]);

        // Random response tables against the model.
        for (int i = 0; i < 6; i++) begin
            rv.mode = 3;
            rv.tbl  = (i == 0) ? GOLD : 8'($urandom);
            rv.exp_tbl  = rv.tbl;
            rv.exp_pass = (rv.tbl == GOLD);
            rv.exp_fidx = ref_fidx(rv.tbl);
            rv.p1 = int'($urandom_range(1, 30));
            rv.p2 = -1;
            run_sweep(rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
